// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory read channel, redirect input and the
// decode-side valid/ready channel. The fetch unit uses the master view.
interface instr_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    input  redirect_valid, redirect_pc,
    output if_valid, if_instr, if_pc,
    input  if_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    output redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_pc,
    output if_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: steers the PC register, issues one-outstanding
// memory reads and buffers returned words in a show-ahead prefetch queue.
// Optional macro FETCH_TRACE_EN adds simulation-only trace printing.
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc_next,
  instr_fetch_if.master     bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_after;
  entry_t            fifo_q [DEPTH];
  logic              push, pop;

  assign pop         = (count_q != '0) && bus.if_ready;
  assign count_after = count_q + CNT_W'(1) - CNT_W'(pop);

  // Next-state, next address, queue push and PC steering.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    pc_next    = pc_in;
    unique case (state_q)
      IDLE: begin
        if (!bus.redirect_valid && count_q < DEPTH_C) begin
          state_d    = REQ;
          mem_addr_d = pc_in;
        end
      end
      REQ: begin
        if (bus.redirect_valid) begin
          // Response arriving with a redirect is dropped on the spot.
          state_d = bus.mem_ack ? IDLE : DRAIN;
        end else if (bus.mem_ack) begin
          push    = 1'b1;
          pc_next = pc_in + ADDR_W'(1);
          if (count_after < DEPTH_C) mem_addr_d = pc_in + ADDR_W'(1);
          else                       state_d    = IDLE;
        end
      end
      DRAIN: begin
        if (bus.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.redirect_valid) pc_next = bus.redirect_pc;
    if (!rst_n)             pc_next = RESET_PC;
  end

  // Control registers and queue pointers; a redirect empties the queue.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      if (bus.redirect_valid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Queue storage write.
  // NOTE: storage has no reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: mem_addr_q, instr: bus.mem_rdata};
  end

  // Reset drops the request line at once so an aborted read is never held.
  assign bus.mem_req  = (state_q != IDLE) && rst_n;
  assign bus.mem_addr = mem_addr_q;
  assign bus.if_valid = (count_q != '0);
  assign bus.if_instr = fifo_q[rd_ptr_q].instr;
  assign bus.if_pc    = fifo_q[rd_ptr_q].pc;

  // Issue gating must keep a push from ever landing on a full queue.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && count_q == DEPTH_C));

`ifdef FETCH_TRACE_EN
  // Simulation trace of queue traffic, redirects and dropped responses.
  always @(posedge clk) begin
    if (rst_n) begin
      if (push) $display("[fetch] push pc=%h instr=%h", mem_addr_q, bus.mem_rdata);
      if (pop)  $display("[fetch] pop  pc=%h", bus.if_pc);
      if (bus.redirect_valid) $display("[fetch] redirect pc=%h", bus.redirect_pc);
      if (bus.mem_ack && ((state_q == REQ && bus.redirect_valid) || state_q == DRAIN))
        $display("[fetch] discard ack addr=%h", mem_addr_q);
    end
  end
`else
  // Trace disabled: no extra logic.
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written
// reset/wrap sequences and a randomized run against a queue-based model.
module tb_instr_fetch;
  localparam int          AW    = 16;
  localparam int          DW    = 16;
  localparam int          DEPTH = 4;
  localparam logic [15:0] RPC   = 16'h0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_q;
  logic [15:0] pc_next;
  int          total = 0;
  int          bad   = 0;

  instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pc_in   (pc_q),
    .pc_next (pc_next),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Program counter register owned by the bench.
  always @(posedge clk) pc_q <= pc_next;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  assign bus.mem_rdata = instr_of(bus.mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ack, input logic rdy, input logic red, input logic [15:0] rpc);
    bus.mem_ack        = ack;
    bus.if_ready       = rdy;
    bus.redirect_valid = red;
    bus.redirect_pc    = rpc;
  endtask

  // Called on a negedge; leaves rst_n just released on a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    #1 check("rst_pc_next", pc_next, RPC);
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h0);
    check("rst_if_valid", bus.if_valid, 1'b0);
    check("rst_pc", pc_q, RPC);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        ack, rdy, red;
    logic [15:0] rpc;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] hpc;
    logic [15:0] pcn;
  } vec_t;

  function automatic vec_t mk(input logic ack, rdy, red, input logic [15:0] rpc,
                              input logic req, input logic [15:0] addr,
                              input logic valid, input logic [15:0] hpc, pcn);
    vec_t v;
    v.ack = ack; v.rdy = rdy; v.red = red; v.rpc = rpc;
    v.req = req; v.addr = addr; v.valid = valid; v.hpc = hpc; v.pcn = pcn;
    return v;
  endfunction

  localparam int NV = 18;
  vec_t tbl [NV];

  // Reference model state for the randomized phase.
  logic [15:0] m_q [$];
  logic        m_busy, m_stale;
  logic [15:0] m_addr, m_pc;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ack rdy red rpc      | req addr    vld hpc      pc_next
    tbl[0]  = mk(0, 1, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0010);
    tbl[1]  = mk(1, 1, 0, 16'h0000,   1, 16'h0010, 0, 16'h0000, 16'h0011);
    tbl[2]  = mk(1, 1, 0, 16'h0000,   1, 16'h0011, 1, 16'h0010, 16'h0012);
    tbl[3]  = mk(1, 0, 0, 16'h0000,   1, 16'h0012, 1, 16'h0011, 16'h0013);
    tbl[4]  = mk(1, 0, 0, 16'h0000,   1, 16'h0013, 1, 16'h0011, 16'h0014);
    tbl[5]  = mk(1, 0, 0, 16'h0000,   1, 16'h0014, 1, 16'h0011, 16'h0015);
    tbl[6]  = mk(0, 0, 0, 16'h0000,   0, 16'h0000, 1, 16'h0011, 16'h0015);
    tbl[7]  = mk(0, 1, 0, 16'h0000,   0, 16'h0000, 1, 16'h0011, 16'h0015);
    tbl[8]  = mk(0, 0, 0, 16'h0000,   0, 16'h0000, 1, 16'h0012, 16'h0015);
    tbl[9]  = mk(0, 0, 1, 16'h0200,   1, 16'h0015, 1, 16'h0012, 16'h0200);
    tbl[10] = mk(1, 0, 0, 16'h0000,   1, 16'h0015, 0, 16'h0000, 16'h0200);
    tbl[11] = mk(0, 0, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0200);
    tbl[12] = mk(1, 1, 0, 16'h0000,   1, 16'h0200, 0, 16'h0000, 16'h0201);
    tbl[13] = mk(1, 1, 1, 16'h0300,   1, 16'h0201, 1, 16'h0200, 16'h0300);
    tbl[14] = mk(0, 1, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0300);
    tbl[15] = mk(1, 1, 0, 16'h0000,   1, 16'h0300, 0, 16'h0000, 16'h0301);
    tbl[16] = mk(0, 1, 0, 16'h0000,   1, 16'h0301, 1, 16'h0300, 16'h0301);
    tbl[17] = mk(0, 1, 0, 16'h0000,   1, 16'h0301, 0, 16'h0000, 16'h0301);

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    do_reset();

    // Directed table: streaming, fill/stall, redirect during wait and with ack.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].ack, tbl[i].rdy, tbl[i].red, tbl[i].rpc);
      #1;
      check($sformatf("tbl%0d_mem_req", i), bus.mem_req, tbl[i].req);
      if (tbl[i].req) check($sformatf("tbl%0d_mem_addr", i), bus.mem_addr, tbl[i].addr);
      check($sformatf("tbl%0d_if_valid", i), bus.if_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        check($sformatf("tbl%0d_if_pc", i), bus.if_pc, tbl[i].hpc);
        check($sformatf("tbl%0d_if_instr", i), bus.if_instr, instr_of(tbl[i].hpc));
      end
      check($sformatf("tbl%0d_pc_next", i), pc_next, tbl[i].pcn);
      @(negedge clk);
    end

    // Reset while a request is outstanding.
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    #1 check("mid_req_before_reset", bus.mem_req, 1'b1);
    do_reset();

    // PC wrap: redirect to 0xFFFF, fetch it, next request at 0x0000.
    drive(1'b0, 1'b1, 1'b1, 16'hFFFF);
    #1 check("wrap_redirect_pc_next", pc_next, 16'hFFFF);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    #1 check("wrap_idle_after_redirect", bus.mem_req, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h0);
    #1;
    check("wrap_req", bus.mem_req, 1'b1);
    check("wrap_addr_ffff", bus.mem_addr, 16'hFFFF);
    check("wrap_pc_next", pc_next, 16'h0000);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    #1;
    check("wrap_addr_0000", bus.mem_addr, 16'h0000);
    check("wrap_if_pc", bus.if_pc, 16'hFFFF);
    check("wrap_if_instr", bus.if_instr, instr_of(16'hFFFF));
    @(negedge clk);

    // Randomized run against the queue model.
    do_reset();
    m_q.delete();
    m_busy  = 1'b0;
    m_stale = 1'b0;
    m_addr  = '0;
    m_pc    = RPC;
    for (int c = 0; c < 3000; c++) begin
      logic        ack, rdy, red, accepted;
      logic [15:0] rpc, exp_pcn;
      int          cnt;
      ack = m_busy && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 6);
      red = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2))
                                        : 16'($urandom);
      drive(ack, rdy, red, rpc);
      #1;
      check("rnd_mem_req", bus.mem_req, m_busy);
      if (m_busy) check("rnd_mem_addr", bus.mem_addr, m_addr);
      check("rnd_if_valid", bus.if_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("rnd_if_pc", bus.if_pc, m_q[0]);
        check("rnd_if_instr", bus.if_instr, instr_of(m_q[0]));
      end
      accepted = m_busy && ack && !m_stale && !red;
      exp_pcn  = red ? rpc : (accepted ? m_pc + 16'd1 : m_pc);
      check("rnd_pc_next", pc_next, exp_pcn);

      cnt = m_q.size();
      if (rdy && cnt > 0) void'(m_q.pop_front());
      if (accepted) m_q.push_back(m_addr);
      if (red) m_q.delete();
      if (m_busy) begin
        if (ack) begin
          if (accepted && m_q.size() < DEPTH) m_addr = m_pc + 16'd1;
          else                                m_busy = 1'b0;
          m_stale = 1'b0;
        end else if (red) begin
          m_stale = 1'b1;
        end
      end else if (!red && cnt < DEPTH) begin
        m_busy = 1'b1;
        m_addr = m_pc;
      end
      m_pc = exp_pcn;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
